ascon_sbox_layer: RTL and testbench
===================================

ASCON_SBOX_LAYER -- requirements
Module: ascon_sbox_layer

Interface
REQ-001 SHALL have parameter LANE_W, default 64, meaning bits per Ascon lane (power of two, >=2); five lanes are fixed.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start one substitution pass
- state_i  in  5*LANE_W  input state; lane k = bits [k*LANE_W +: LANE_W], lane0 = x0
- busy_o  out  1  pass in progress
- done_o  out  1  one-cycle completion pulse
- state_o  out  5*LANE_W  substituted state, same packing as state_i
- cfg_we_i  in  1  S-box row write request
- cfg_addr_i  in  5  row write address, [4:2] = row
- cfg_data_i  in  20  row payload
- cfg_ready_o  out  1  row write accepted this cycle
- sbox_update_o  out  1  write enable to S-box LUT
- sbox_addr_o  out  5  LUT address, [4:2] = row, [1:0] = column
- sbox_wdata_o  out  20  LUT row payload
- sbox_data_i  in  5  combinational LUT read data

Function
REQ-003 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-004 IDLE: on start_i=1, SHALL capture state_i into the working register, clear column counter, and go to RUN.
REQ-005 RUN: for column i = counter, SHALL drive sbox_addr_o = {x0[i],x1[i],x2[i],x3[i],x4[i]} (x0 = MSB) and write sbox_data_i bits [4:0] back to x0[i]..x4[i] at the same clock edge.
REQ-006 RUN: SHALL increment the counter each cycle; after column LANE_W-1 is written, SHALL go to DONE.
REQ-007 DONE: SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-008 Latency: start_i sampled at edge T -> done_o high during cycle T+LANE_W+1; busy_o high during RUN cycles only, exactly LANE_W cycles.
REQ-009 state_o SHALL always reflect the working register; it holds the result until the next accepted start.
REQ-010 start_i outside IDLE SHALL be ignored; no queuing.
REQ-011 cfg_ready_o SHALL equal (FSM==IDLE) && !start_i; start has priority over a simultaneous cfg write.
REQ-012 When cfg_we_i && cfg_ready_o: SHALL drive sbox_update_o=1, sbox_addr_o=cfg_addr_i, sbox_wdata_o=cfg_data_i in that cycle only.
REQ-013 sbox_update_o SHALL never be asserted in RUN or DONE; a cfg write pending during a pass stalls (cfg_ready_o=0) until IDLE.
REQ-014 Outside a cfg write, sbox_wdata_o SHALL be 0; in IDLE/DONE without a write, sbox_addr_o SHALL be 0.
REQ-015 Counter width SHALL be $clog2(LANE_W); it SHALL not wrap beyond LANE_W-1 within one pass.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, counter 0, working register 0, and all outputs (busy_o, done_o, state_o, cfg_ready_o, sbox_update_o, sbox_addr_o, sbox_wdata_o) to 0 while asserted.
REQ-017 Reset mid-pass SHALL abandon the pass without a done_o pulse; the first start after release SHALL behave per REQ-004.

Structure
REQ-018 The FSM state typedef, lane count (5), and LUT geometry constants (COL_W=5, COLS=4, ROWS=8, row payload width 20) SHALL live in the shared ascon package.
REQ-019 The S-box LUT SHALL stay external; the block SHALL be flat, with no sub-module instances.

Verification
REQ-020 The bench SHALL model the LUT behaviourally (8x20-bit rows, combinational read, synchronous write) and cover:
- Load standard Ascon S-box via 8 cfg writes, then all-zero state + start -> done_o at T+65; lane2 = 64'hFFFF_FFFF_FFFF_FFFF; other lanes 0 (S(0)=0x04).
- Same table, x0=x1=x2=x3=x4=64'h1 -> column 0 maps 0x1F->0x17 and columns 1..63 map 0->0x04; compare against a reference model.
- start_i pulsed again at RUN cycle 10 -> ignored; single done_o; result unchanged vs. REQ-020 second case.
- cfg_we_i held high from RUN cycle 5 -> cfg_ready_o=0 and no sbox_update_o until IDLE; write accepted in the first IDLE cycle after done_o.
- start_i and cfg_we_i both high in IDLE -> pass starts; cfg_ready_o=0 that cycle; no LUT write.
- rst_n low at RUN cycle 30 -> all outputs 0 immediately; no done_o; a fresh pass after release matches the model.

Source files
------------

// File: rtl/ascon_sbox_layer_pkg.sv
// Shared constants and types for the Ascon bit-sliced S-box substitution layer.
package ascon_sbox_layer_pkg;

    localparam int unsigned NUM_LANES = 5;
    localparam int unsigned COL_W     = 5;
    localparam int unsigned COLS      = 4;
    localparam int unsigned ROWS      = 8;
    localparam int unsigned ROW_W     = COL_W * COLS;
    localparam int unsigned ROW_IDX_W = $clog2(ROWS);
    localparam int unsigned COL_IDX_W = $clog2(COLS);
    localparam int unsigned ADDR_W    = ROW_IDX_W + COL_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sbox_state_e;

endpackage

// File: rtl/ascon_sbox_layer.sv
// Ascon substitution layer: walks the 5-lane state one bit-column per cycle through
// an external 32x5 LUT, and arbitrates LUT row writes while idle.
module ascon_sbox_layer
    import ascon_sbox_layer_pkg::*;
#(
    parameter int unsigned LANE_W = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [NUM_LANES*LANE_W-1:0]   state_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [NUM_LANES*LANE_W-1:0]   state_o,
    input  logic                          cfg_we_i,
    input  logic [ADDR_W-1:0]             cfg_addr_i,
    input  logic [ROW_W-1:0]              cfg_data_i,
    output logic                          cfg_ready_o,
    output logic                          sbox_update_o,
    output logic [ADDR_W-1:0]             sbox_addr_o,
    output logic [ROW_W-1:0]              sbox_wdata_o,
    input  logic [COL_W-1:0]              sbox_data_i
);

    localparam int unsigned CNT_W = $clog2(LANE_W);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(LANE_W - 1);

    sbox_state_e                         state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [NUM_LANES-1:0][LANE_W-1:0]    work_q, work_d;
    logic [COL_W-1:0]                    col_bits;
    logic                                accept_start;

    assign accept_start = (state_q == ST_IDLE) && start_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i)           state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST_COL) state_d = ST_DONE;
            ST_DONE:                        state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // Current column, x0 in the MSB
    always_comb begin
        col_bits = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            col_bits[COL_W-1-k] = work_q[k][cnt_q];
        end
    end

    // Outputs; the LUT port is combinational so the read lands in the same cycle
    always_comb begin
        busy_o        = 1'b0;
        done_o        = 1'b0;
        cfg_ready_o   = 1'b0;
        sbox_update_o = 1'b0;
        sbox_addr_o   = '0;
        sbox_wdata_o  = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Reset gating keeps the write handshake dead while rst_n is low
                cfg_ready_o = rst_n && !start_i;
                if (cfg_we_i && cfg_ready_o) begin
                    sbox_update_o = 1'b1;
                    sbox_addr_o   = cfg_addr_i;
                    sbox_wdata_o  = cfg_data_i;
                end
            end
            ST_RUN: begin
                busy_o      = 1'b1;
                sbox_addr_o = col_bits;
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    // Working register and column counter next-state
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        if (accept_start) begin
            work_d = state_i;
            cnt_d  = '0;
        end else if (state_q == ST_RUN) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                work_d[k][cnt_q] = sbox_data_i[COL_W-1-k];
            end
            if (cnt_q != LAST_COL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
        end
    end

    assign state_o = work_q;

endmodule

// File: tb/tb_ascon_sbox_layer.sv
// Self-checking bench for ascon_sbox_layer with a behavioural 8x20 S-box LUT.
module tb_ascon_sbox_layer;

    localparam int unsigned LW = 64;
    localparam int unsigned SW = 5 * LW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [SW-1:0] state_i;
    logic          busy_o, done_o;
    logic [SW-1:0] state_o;
    logic          cfg_we_i;
    logic [4:0]    cfg_addr_i;
    logic [19:0]   cfg_data_i;
    logic          cfg_ready_o, sbox_update_o;
    logic [4:0]    sbox_addr_o;
    logic [19:0]   sbox_wdata_o;
    logic [4:0]    sbox_data;

    int n_checks = 0;
    int n_fail   = 0;

    int sbox_tab [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                          30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};

    always #5 clk = ~clk;

    ascon_sbox_layer #(.LANE_W(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .state_i       (state_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .state_o       (state_o),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_data_i    (cfg_data_i),
        .cfg_ready_o   (cfg_ready_o),
        .sbox_update_o (sbox_update_o),
        .sbox_addr_o   (sbox_addr_o),
        .sbox_wdata_o  (sbox_wdata_o),
        .sbox_data_i   (sbox_data)
    );

    // LUT: 8 rows of four 5-bit entries, column c at bits [5c +: 5]
    logic [19:0] lut [8];
    logic [19:0] lut_row;
    always_comb begin
        lut_row   = lut[sbox_addr_o[4:2]];
        sbox_data = lut_row[int'(sbox_addr_o[1:0]) * 5 +: 5];
    end
    always @(posedge clk) if (sbox_update_o) lut[sbox_addr_o[4:2]] <= sbox_wdata_o;

    function automatic logic [SW-1:0] pack(input logic [LW-1:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    // Reference: each bit-column is a 5-bit value (x0 = MSB) substituted via the table
    function automatic logic [SW-1:0] model(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        logic [4:0]    v, o;
        r = s;
        for (int i = 0; i < LW; i++) begin
            for (int k = 0; k < 5; k++) v[4-k] = s[k*LW + i];
            o = 5'(sbox_tab[int'(v)]);
            for (int k = 0; k < 5; k++) r[k*LW + i] = o[4-k];
        end
        return r;
    endfunction

    function automatic logic [19:0] std_row(input int r);
        return {5'(sbox_tab[4*r+3]), 5'(sbox_tab[4*r+2]), 5'(sbox_tab[4*r+1]), 5'(sbox_tab[4*r])};
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] s;
        for (int j = 0; j < SW/32; j++) s[j*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] row, input logic [19:0] d);
        @(negedge clk);
        cfg_we_i = 1'b1; cfg_addr_i = {row, 2'b00}; cfg_data_i = d;
        #1;
        chk("cfg_ready", SW'(cfg_ready_o), SW'(1));
        chk("cfg_update", SW'(sbox_update_o), SW'(1));
        chk("cfg_addr", SW'(sbox_addr_o), SW'({row, 2'b00}));
        chk("cfg_wdata", SW'(sbox_wdata_o), SW'(d));
        @(posedge clk); #1;
        cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    endtask

    // mode: 0 plain, 1 restart at RUN cycle 10, 2 cfg held from RUN cycle 5,
    //       3 start+cfg together in IDLE, 4 reset at RUN cycle 30
    task automatic run_pass(input logic [SW-1:0] st, input int mode, output logic [SW-1:0] res);
        int edges, busy_cnt, done_cnt, done_at, viol;
        @(negedge clk);
        state_i = st; start_i = 1'b1;
        if (mode == 3) begin cfg_we_i = 1'b1; cfg_addr_i = 5'd0; cfg_data_i = 20'hFFFFF; end
        #1;
        chk("ready_low_on_start", SW'(cfg_ready_o), SW'(0));
        if (mode == 3) chk("no_update_on_start", SW'(sbox_update_o), SW'(0));
        @(posedge clk); #1;
        start_i = 1'b0; cfg_we_i = 1'b0; cfg_data_i = '0;
        edges = 0; busy_cnt = 0; done_cnt = 0; done_at = -1; viol = 0;
        while (edges < 3*LW && !(done_at >= 0 && edges > done_at + 1)) begin
            @(negedge clk);
            if (mode == 4 && edges == 30) begin
                rst_n = 1'b0; #1;
                chk("reset_outputs_zero",
                    SW'({busy_o, done_o, cfg_ready_o, sbox_update_o, sbox_addr_o, sbox_wdata_o}), SW'(0));
                chk("reset_state_zero", state_o, '0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int c = 0; c < LW + 5; c++) begin
                    @(negedge clk);
                    if (done_o || busy_o) done_cnt++;
                end
                chk("no_done_after_reset", SW'(done_cnt), SW'(0));
                res = state_o;
                return;
            end
            if (busy_o) busy_cnt++;
            if (done_o) begin done_cnt++; if (done_at < 0) done_at = edges; end
            if ((busy_o || done_o) && (sbox_update_o || sbox_wdata_o != '0)) viol++;
            if (mode == 1) start_i = (edges == 10);
            if (mode == 2 && edges == 5) begin
                cfg_we_i = 1'b1; cfg_addr_i = 5'd0; cfg_data_i = std_row(0);
            end
            if (mode == 2 && edges >= 5) begin
                #1;
                if ((busy_o || done_o) && (cfg_ready_o || sbox_update_o)) viol++;
                if (done_at >= 0 && edges == done_at + 1) begin
                    chk("cfg_ready_first_idle", SW'(cfg_ready_o), SW'(1));
                    chk("cfg_update_first_idle", SW'(sbox_update_o), SW'(1));
                end
            end
            @(posedge clk); edges++;
        end
        #1;
        cfg_we_i = 1'b0; cfg_data_i = '0; start_i = 1'b0;
        chk("done_latency", SW'(done_at), SW'(LW));
        chk("done_single_pulse", SW'(done_cnt), SW'(1));
        chk("busy_cycles", SW'(busy_cnt), SW'(LW));
        chk("no_lut_activity_in_pass", SW'(viol), SW'(0));
        res = state_o;
    endtask

    typedef struct {
        string         name;
        logic [SW-1:0] st;
        logic [SW-1:0] exp;
    } vec_t;

    initial begin
        vec_t          vecs [3];
        logic [SW-1:0] res, st, held;
        logic [LW-1:0] ones;
        ones = '1;

        vecs[0] = '{"zero_state", '0, pack('0, '0, ones, '0, '0)};
        vecs[1] = '{"lanes_one", pack(64'h1, 64'h1, 64'h1, 64'h1, 64'h1),
                    pack(64'h1, '0, ones, 64'h1, 64'h1)};
        vecs[2] = '{"all_ones", pack(ones, ones, ones, ones, ones),
                    pack(ones, '0, ones, ones, ones)};

        rst_n = 1'b0; start_i = 1'b0; state_i = '0;
        cfg_we_i = 1'b1; cfg_addr_i = 5'd4; cfg_data_i = 20'h12345;
        repeat (2) @(negedge clk);
        chk("rst_outputs", SW'({busy_o, done_o, cfg_ready_o, sbox_update_o, sbox_addr_o, sbox_wdata_o}), SW'(0));
        chk("rst_state", state_o, '0);
        cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_ready", SW'(cfg_ready_o), SW'(1));
        chk("idle_quiet", SW'({busy_o, done_o, sbox_update_o, sbox_addr_o, sbox_wdata_o}), SW'(0));

        for (int r = 0; r < 8; r++) cfg_write(3'(r), std_row(r));

        foreach (vecs[i]) begin
            run_pass(vecs[i].st, 0, res);
            chk({vecs[i].name, "_table"}, res, vecs[i].exp);
            chk({vecs[i].name, "_model"}, res, model(vecs[i].st));
        end

        held = state_o;
        repeat (3) @(negedge clk);
        chk("result_held", state_o, held);

        run_pass(vecs[1].st, 1, res);
        chk("restart_ignored", res, vecs[1].exp);
        run_pass(vecs[1].st, 2, res);
        chk("cfg_stall_result", res, vecs[1].exp);
        run_pass(vecs[0].st, 3, res);
        chk("start_beats_cfg", res, model(vecs[0].st));

        st = rand_state();
        run_pass(st, 4, res);
        chk("abandoned_pass_state", res, '0);
        st = rand_state();
        run_pass(st, 0, res);
        chk("pass_after_reset", res, model(st));

        for (int n = 0; n < 12; n++) begin
            st = rand_state();
            run_pass(st, 0, res);
            chk("random_pass", res, model(st));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
